wb_stage: RTL and testbench

//  Writeback stage directly upstream of the 64-bit register file write port. Accepts ALU results
//  and raw load data over valid/ready, gives loads priority, and does byte-lane extraction and

---
 rtl/wb_stage.sv | 125 ++++++++++++
 tb/tb_wb_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU/load results, extracts load lanes, drives the
// registered register-file write port and a pending-write scoreboard. Optional: WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [IDXW-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [IDXW-1:0] ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_raw,
  input  logic            iss_valid,
  input  logic [IDXW-1:0] iss_rd,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_idx,
  output logic [XLEN-1:0] wr_data,
  output logic [NREG-1:0] busy
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt
`endif
);

  function automatic logic [63:0] load_extract(input logic [2:0] funct3,
                                               input logic [2:0] addr_lo,
                                               input logic [63:0] raw);
    logic [2:0]  lane;
    logic [63:0] sh;
    // low address bits below the access size are ignored
    case (funct3[1:0])
      2'd0:    lane = addr_lo;
      2'd1:    lane = {addr_lo[2:1], 1'b0};
      2'd2:    lane = {addr_lo[2], 2'b00};
      default: lane = 3'd0;
    endcase
    sh = raw >> {lane, 3'b000};
    case (funct3)
      3'd0:    load_extract = {{56{sh[7]}}, sh[7:0]};
      3'd1:    load_extract = {{48{sh[15]}}, sh[15:0]};
      3'd2:    load_extract = {{32{sh[31]}}, sh[31:0]};
      3'd3:    load_extract = sh;
      3'd4:    load_extract = {56'd0, sh[7:0]};
      3'd5:    load_extract = {48'd0, sh[15:0]};
      3'd6:    load_extract = {32'd0, sh[31:0]};
      default: load_extract = 64'd0;
    endcase
  endfunction

  logic            ld_xfer_s;
  logic            alu_xfer_s;
  logic [NREG-1:0] set_s;
  logic [NREG-1:0] clr_s;

  assign ld_ready   = !reset;
  assign alu_ready  = !reset && !ld_valid;
  assign ld_xfer_s  = ld_valid && ld_ready;
  assign alu_xfer_s = alu_valid && alu_ready;

  // Write port register: load has priority, x0 writes are retired silently
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_idx  <= {IDXW{1'b0}};
      wr_data <= {XLEN{1'b0}};
    end else if (ld_xfer_s) begin
      wr_en   <= (ld_rd != {IDXW{1'b0}});
      wr_idx  <= ld_rd;
      wr_data <= load_extract(ld_funct3, ld_addr_lo, ld_raw);
    end else if (alu_xfer_s) begin
      wr_en   <= (alu_rd != {IDXW{1'b0}});
      wr_idx  <= alu_rd;
      wr_data <= alu_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Scoreboard set/clear masks; register 0 is never tracked
  always_comb begin
    set_s = {NREG{1'b0}};
    clr_s = {NREG{1'b0}};
    if (iss_valid) begin
      set_s[iss_rd] = 1'b1;
    end else begin
      set_s = {NREG{1'b0}};
    end
    if (wr_en) begin
      clr_s[wr_idx] = 1'b1;
    end else begin
      clr_s = {NREG{1'b0}};
    end
    set_s[0] = 1'b0;
  end

  // Scoreboard register: set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= {NREG{1'b0}};
    end else begin
      busy <= (busy & ~clr_s) | set_s;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Retired-transfer counter, wraps naturally at 2^64
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= 64'd0;
    end else if (ld_xfer_s || alu_xfer_s) begin
      retire_cnt <= retire_cnt + 64'd1;
    end else begin
      retire_cnt <= retire_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage: expected writes are queued at drive time
// and compared one cycle later against the registered write port and busy vector.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [2:0]  ld_addr_lo;
  logic [63:0] ld_raw;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [63:0] wr_data;
  logic [31:0] busy;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  wb_stage dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .ld_raw(ld_raw),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic        full;
    logic [4:0]  idx;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [4:0]  m_idx = 5'd0;
  logic [63:0] m_data = 64'd0;
  logic        m_known = 1'b0;
  logic        cur_en = 1'b0;
  logic [4:0]  cur_idx = 5'd0;
  logic [31:0] busy_m = 32'd0;
  logic [63:0] cnt_m = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [2:0] f, input logic [2:0] a,
                                           input logic [63:0] raw);
    int nb, off;
    logic [63:0] v;
    if (f == 3'd7) return 64'd0;
    nb  = 1 << f[1:0];
    off = int'(a) - (int'(a) % nb);
    v   = 64'd0;
    for (int i = 0; i < nb; i++) v[i*8 +: 8] = raw[(off+i)*8 +: 8];
    if (!f[2] && nb < 8 && v[nb*8-1]) begin
      for (int b = nb*8; b < 64; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic cycle();
    exp_t e;
    logic erl, era, ld_x, alu_x;
    logic [31:0] setm, clrm;
    #1;
    erl = !reset;
    era = !reset && !ld_valid;
    chk("ld_ready", {63'd0, ld_ready}, {63'd0, erl});
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, era});
    ld_x  = ld_valid && erl;
    alu_x = alu_valid && era;
    setm = 32'd0; clrm = 32'd0;
    if (iss_valid && iss_rd != 5'd0) setm[iss_rd] = 1'b1;
    if (cur_en) clrm[cur_idx] = 1'b1;
    if (reset) begin
      m_idx = 5'd0; m_data = 64'd0; m_known = 1'b1;
      e = '{en: 1'b0, full: 1'b1, idx: 5'd0, data: 64'd0};
      busy_m = 32'd0; cnt_m = 64'd0;
    end else begin
      if (ld_x || alu_x) begin
        logic [4:0] rd;
        logic [63:0] d;
        rd = ld_x ? ld_rd : alu_rd;
        d  = ld_x ? ref_load(ld_funct3, ld_addr_lo, ld_raw) : alu_data;
        cnt_m = cnt_m + 64'd1;
        if (rd != 5'd0) begin
          m_idx = rd; m_data = d; m_known = 1'b1;
          e = '{en: 1'b1, full: 1'b1, idx: rd, data: d};
        end else begin
          m_known = 1'b0;
          e = '{en: 1'b0, full: 1'b0, idx: 5'd0, data: 64'd0};
        end
      end else begin
        e = '{en: 1'b0, full: m_known, idx: m_idx, data: m_data};
      end
      busy_m = (busy_m & ~clrm) | setm;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("wr_en", {63'd0, wr_en}, {63'd0, e.en});
    if (e.full) begin
      chk("wr_idx", {59'd0, wr_idx}, {59'd0, e.idx});
      chk("wr_data", wr_data, e.data);
    end
    chk("busy", {32'd0, busy}, {32'd0, busy_m});
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, cnt_m);
`endif
    cur_en = e.en; cur_idx = e.idx;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [63:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [2:0] f, input logic [2:0] a,
                    input logic [63:0] raw);
    ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f; ld_addr_lo = a; ld_raw = raw;
  endtask

  initial begin
    reset = 1'b1; idle();
    alu_rd = 5'd0; alu_data = 64'd0; ld_rd = 5'd0; ld_funct3 = 3'd0;
    ld_addr_lo = 3'd0; ld_raw = 64'd0; iss_rd = 5'd0;
    @(posedge clk); #1;
    cycle(); cycle();
    reset = 1'b0;
    cycle();

    // basic ALU write, then idle holds idx/data with wr_en low
    alu(5'd5, 64'h1234); cycle(); idle(); cycle(); cycle();

    // load beats ALU; ALU retires next cycle unchanged
    alu(5'd6, 64'hDEAD_BEEF_0000_0001); ld(5'd8, 3'd3, 3'd0, 64'h0123_4567_89AB_CDEF);
    cycle(); ld_valid = 1'b0; cycle(); idle(); cycle();

    // lane extraction corner cases
    ld(5'd10, 3'd0, 3'd3, 64'h0000_0000_8000_0000); cycle();
    ld(5'd10, 3'd4, 3'd3, 64'h0000_0000_8000_0000); cycle();
    ld(5'd11, 3'd2, 3'd4, 64'h7FFF_FFFF_0000_0000); cycle();
    ld(5'd12, 3'd7, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF); cycle();
    ld(5'd13, 3'd1, 3'd7, 64'h8001_0000_0000_0000); cycle();
    ld(5'd13, 3'd5, 3'd7, 64'h8001_0000_0000_0000); cycle();
    ld(5'd14, 3'd6, 3'd5, 64'hF000_0001_0000_0000); cycle();
    for (int i = 0; i < 24; i++) begin
      ld(5'($urandom_range(1, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
         {$urandom, $urandom});
      cycle();
    end
    idle(); cycle();

    // scoreboard: set, set-beats-clear, clear, x0 issue ignored
    iss_valid = 1'b1; iss_rd = 5'd7; cycle();
    iss_valid = 1'b0; alu(5'd7, 64'h77); cycle();
    alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7; cycle();
    iss_valid = 1'b0; cycle();
    iss_valid = 1'b1; iss_rd = 5'd9; cycle();
    iss_valid = 1'b0; ld(5'd9, 3'd3, 3'd0, 64'h99); cycle();
    ld_valid = 1'b0; cycle(); cycle();
    iss_valid = 1'b1; iss_rd = 5'd0; cycle();
    idle(); cycle();

    // x0 write is accepted but never enables the port
    alu(5'd0, 64'hFF); cycle(); idle(); cycle();
    alu(5'd4, 64'h4444); cycle(); idle(); cycle();

    // reset during a presented transfer drops everything
    iss_valid = 1'b1; iss_rd = 5'd3; alu(5'd3, 64'h3333); cycle();
    alu(5'd2, 64'h2222); ld(5'd1, 3'd0, 3'd0, 64'h11); reset = 1'b1; cycle();
    cycle();
    idle(); reset = 1'b0; cycle();
    alu(5'd31, 64'hFFFF_FFFF_FFFF_FFFF); cycle(); idle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
